all_gates: RTL and testbench

- Two-input logic-gate reference block.
- Drives seven combinational gate outputs (AND, NAND, OR, NOR, XOR, XNOR, NOT) from inputs a and b.
- Also provides a registered snapshot of all seven results, an input-change pulse and a saturating change counter.
- Used as a basic-logic sanity block and bring-up fixture in the gate-level exercise suite.

---
 rtl/all_gates.sv | 52 +++++
 tb/tb_all_gates.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/all_gates.sv
// all_gates: two-input gate reference with registered snapshot, change pulse and saturating change counter
module all_gates #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             and_out,
  output logic             nand_out,
  output logic             or_out,
  output logic             nor_out,
  output logic             xor_out,
  output logic             xnor_out,
  output logic             not_out,
  output logic [6:0]       gates_q,
  output logic             in_changed,
  output logic [CNT_W-1:0] change_cnt
);
  logic             a_q, b_q, in_changed_q, in_changed_d;
  logic [6:0]       gates_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
  assign and_out  = a & b;
  assign nand_out = ~and_out;
  assign or_out   = a | b;
  assign nor_out  = ~or_out;
  assign xor_out  = a ^ b;
  assign xnor_out = ~xor_out;
  assign not_out  = ~a;
  always_comb begin
    gates_d      = {not_out, xnor_out, xor_out, nor_out, or_out, nand_out, and_out};
    in_changed_d = (a != a_q) || (b != b_q);
    change_cnt_d = (in_changed_d && change_cnt_q != {CNT_W{1'b1}}) ? change_cnt_q + 1'b1 : change_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      gates_q      <= 7'd0;
      in_changed_q <= 1'b0;
      change_cnt_q <= '0;
    end else begin
      a_q          <= a;
      b_q          <= b;
      gates_q      <= gates_d;
      in_changed_q <= in_changed_d;
      change_cnt_q <= change_cnt_d;
    end
  end
  assign in_changed = in_changed_q;
  assign change_cnt = change_cnt_q;
endmodule

// File: tb/tb_all_gates.sv
// tb_all_gates: scoreboard bench for all_gates; expected snapshots are queued on drive and popped after each edge
module tb_all_gates;
  logic       clk = 1'b0, rst_n = 1'b0, a = 1'b0, b = 1'b0;
  logic       and_out, nand_out, or_out, nor_out, xor_out, xnor_out, not_out;
  logic [6:0] gates_q, gates2_q;
  logic       in_changed, in_changed2;
  logic [7:0] change_cnt;
  logic [1:0] change_cnt2;
  logic       and2, nand2, or2, nor2, xor2, xnor2, not2;
  typedef struct packed {
    logic [6:0] g;
    logic       ch;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  exp_t       sb[$];
  exp_t       e;
  logic [6:0] tt [4];
  logic       a_m, b_m;
  logic [7:0] cnt_m;
  logic [1:0] cnt2_m;
  int         tests = 0, failed = 0;

  all_gates dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .and_out(and_out), .nand_out(nand_out), .or_out(or_out), .nor_out(nor_out),
    .xor_out(xor_out), .xnor_out(xnor_out), .not_out(not_out),
    .gates_q(gates_q), .in_changed(in_changed), .change_cnt(change_cnt)
  );
  all_gates #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .and_out(and2), .nand_out(nand2), .or_out(or2), .nor_out(nor2),
    .xor_out(xor2), .xnor_out(xnor2), .not_out(not2),
    .gates_q(gates2_q), .in_changed(in_changed2), .change_cnt(change_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Bit order {not, xnor, xor, nor, or, nand, and}, indexed by {a,b}
  initial begin
    tt[0] = 7'b1101010;
    tt[1] = 7'b1010110;
    tt[2] = 7'b0010110;
    tt[3] = 7'b0100101;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_m = 1'b0; b_m = 1'b0; cnt_m = '0; cnt2_m = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_edge(input logic av, input logic bv);
    exp_t x;
    logic chg;
    a = av; b = bv;
    chg = (av !== a_m) || (bv !== b_m);
    if (chg && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
    if (chg && cnt2_m != 2'd3) cnt2_m = cnt2_m + 2'd1;
    a_m = av; b_m = bv;
    x.g = tt[{av, bv}]; x.ch = chg; x.cnt = cnt_m; x.cnt2 = cnt2_m;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_truth_table();
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = i[1:0];
      a = v[1]; b = v[0];
      #10;
      tests++;
      if ({not_out, xnor_out, xor_out, nor_out, or_out, nand_out, and_out} !== tt[i]) begin
        failed++;
        $display("FAIL truth_table ab=%b got %b exp %b", v,
                 {not_out, xnor_out, xor_out, nor_out, or_out, nand_out, and_out}, tt[i]);
      end
      tests++;
      if (nand_out !== ~and_out || nor_out !== ~or_out || xnor_out !== ~xor_out) begin
        failed++;
        $display("FAIL invariants ab=%b nand=%b and=%b nor=%b or=%b xnor=%b xor=%b",
                 v, nand_out, and_out, nor_out, or_out, xnor_out, xor_out);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    drive_edge(1'b1, 1'b1);
    drive_edge(1'b1, 1'b1);
    while (sb.size() > 0) e = sb.pop_front();
    tests++;
    if (gates_q !== 7'h25) begin
      failed++;
      $display("FAIL reset_pre gates_q got %h exp %h", gates_q, 7'h25);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (gates_q !== 7'h00 || in_changed !== 1'b0 || change_cnt !== 8'd0) begin
      failed++;
      $display("FAIL reset_async gates_q=%h in_changed=%b change_cnt=%0d exp 0/0/0",
               gates_q, in_changed, change_cnt);
    end
    tests++;
    if (and_out !== 1'b1 || xnor_out !== 1'b1) begin
      failed++;
      $display("FAIL reset_comb and=%b xnor=%b exp 1/1", and_out, xnor_out);
    end
  endtask

  task automatic test_latency();
    apply_reset();
    drive_edge(1'b1, 1'b1);
    drive_edge(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      if (i == 0) begin
        tests++;
        if (e.g !== 7'b0100101 || e.ch !== 1'b1 || e.cnt !== 8'd1) begin
          failed++;
          $display("FAIL latency_model g=%b ch=%b cnt=%0d", e.g, e.ch, e.cnt);
        end
      end
    end
    tests++;
    if (gates_q !== 7'b0100101 || in_changed !== 1'b0 || change_cnt !== 8'd1) begin
      failed++;
      $display("FAIL latency_hold gates_q=%b in_changed=%b cnt=%0d exp 0100101/0/1",
               gates_q, in_changed, change_cnt);
    end
  endtask

  task automatic test_first_edge();
    apply_reset();
    drive_edge(1'b1, 1'b1);
    e = sb.pop_front();
    tests++;
    if (gates_q !== e.g || in_changed !== e.ch || change_cnt !== e.cnt) begin
      failed++;
      $display("FAIL first_edge gates_q=%h/%h in_changed=%b/%b cnt=%0d/%0d",
               gates_q, e.g, in_changed, e.ch, change_cnt, e.cnt);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] v;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      v = i[1:0];
      drive_edge(v[1], v[0]);
      e = sb.pop_front();
      tests++;
      if (gates_q !== e.g || in_changed !== e.ch || change_cnt !== e.cnt) begin
        failed++;
        $display("FAIL sequence step=%0d gates_q=%h/%h in_changed=%b/%b cnt=%0d/%0d",
                 i, gates_q, e.g, in_changed, e.ch, change_cnt, e.cnt);
      end
    end
    tests++;
    if (change_cnt !== 8'd3) begin
      failed++;
      $display("FAIL sequence_total change_cnt got %0d exp 3", change_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ref_cnt [6];
    ref_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_edge(~a, b);
      e = sb.pop_front();
      tests++;
      if (change_cnt2 !== e.cnt2 || change_cnt2 !== ref_cnt[i] || in_changed2 !== 1'b1) begin
        failed++;
        $display("FAIL saturation edge=%0d cnt2 got %0d exp %0d in_changed2=%b",
                 i, change_cnt2, ref_cnt[i], in_changed2);
      end
      tests++;
      if (change_cnt !== e.cnt) begin
        failed++;
        $display("FAIL saturation_wide edge=%0d cnt got %0d exp %0d", i, change_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    drive_edge(1'b0, 1'b1);
    e = sb.pop_front();
    drive_edge(1'b0, 1'b1);
    e = sb.pop_front();
    a = 1'b1;
    #2;
    a = 1'b0;
    drive_edge(1'b0, 1'b1);
    e = sb.pop_front();
    tests++;
    if (in_changed !== 1'b0 || in_changed !== e.ch || change_cnt !== e.cnt || change_cnt !== 8'd1) begin
      failed++;
      $display("FAIL glitch in_changed=%b exp 0 change_cnt=%0d exp 1", in_changed, change_cnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++) drive_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    while (sb.size() > 1) e = sb.pop_front();
    e = sb.pop_front();
    tests++;
    if (gates_q !== e.g || in_changed !== e.ch || change_cnt !== e.cnt) begin
      failed++;
      $display("FAIL back_to_back gates_q=%h/%h in_changed=%b/%b cnt=%0d/%0d",
               gates_q, e.g, in_changed, e.ch, change_cnt, e.cnt);
    end
  endtask

  initial begin
    test_truth_table();
    test_reset();
    test_latency();
    test_first_edge();
    test_sequence();
    test_saturation();
    test_glitch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
